// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and types for the 16x9 FIFO.
// Pointers carry one extra wrap bit above the address bits.
package fifo_pkg;

  localparam int FIFO_ADDR_W   = 4;
  localparam int FIFO_DATA_W   = 9;
  localparam int FIFO_DEPTH    = 1 << FIFO_ADDR_W;
  localparam int FIFO_AF_LEVEL = 14;
  localparam int FIFO_AE_LEVEL = 2;

  typedef logic [FIFO_ADDR_W:0] fifo_ptr_t;

endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: wrap-bit pointer with increment enable.
// Low bits roll over naturally and the MSB toggles on wrap.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int W = FIFO_ADDR_W + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  // advance on each accepted access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer/flag controller for the 16x9 FIFO memory.
// Optional FIFO_ERR_FLAGS_EN adds sticky overflow/underflow flags.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W   = FIFO_ADDR_W,
  parameter int AF_LEVEL = FIFO_AF_LEVEL,
  parameter int AE_LEVEL = FIFO_AE_LEVEL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
`ifdef FIFO_ERR_FLAGS_EN
  input  logic              err_clr,
  output logic              overflow,
  output logic              underflow,
`endif
  output logic              we,
  output logic [ADDR_W-1:0] write_addr,
  output logic              re,
  output logic [ADDR_W-1:0] read_addr,
  output logic              push_ack,
  output logic              pop_ack,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] AF_CNT = AF_LEVEL[ADDR_W:0];
  localparam logic [ADDR_W:0] AE_CNT = AE_LEVEL[ADDR_W:0];

  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic            wrap_diff;
  logic            low_eq;
  logic            inc_only;
  logic            dec_only;

  fifo_ptr #(.W(ADDR_W + 1)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (we),
    .ptr (wr_ptr)
  );

  fifo_ptr #(.W(ADDR_W + 1)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (re),
    .ptr (rd_ptr)
  );

  assign wrap_diff = wr_ptr[ADDR_W] != rd_ptr[ADDR_W];
  assign low_eq    = wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0];

  assign full  = wrap_diff && low_eq;
  assign empty = wr_ptr == rd_ptr;

  // reset blocks acks even though the pointers read empty
  assign re = pop && !empty && !rst;
  assign we = push && (!full || re) && !rst;

  assign pop_ack    = re;
  assign push_ack   = we;
  assign write_addr = wr_ptr[ADDR_W-1:0];
  assign read_addr  = rd_ptr[ADDR_W-1:0];

  assign almost_full  = count >= AF_CNT;
  assign almost_empty = count <= AE_CNT;

  assign inc_only = we && !re;
  assign dec_only = re && !we;

  // occupancy tracks single-sided accesses only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      unique case (1'b1)
        inc_only: count <= count + 1'b1;
        dec_only: count <= count - 1'b1;
        default:  count <= count;
      endcase
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic push_drop;
  logic pop_drop;

  assign push_drop = push && !we;
  assign pop_drop  = pop && !re;

  // sticky error flags; a new event beats a clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_drop) begin
        overflow <= 1'b1;
      end else if (err_clr) begin
        overflow <= 1'b0;
      end
      if (pop_drop) begin
        underflow <= 1'b1;
      end else if (err_clr) begin
        underflow <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: table vectors plus data scoreboard for fifo_ctrl.
// Define FIFO_ERR_FLAGS_EN to also exercise overflow/underflow.
module tb_fifo_ctrl;
  import fifo_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       push;
  logic       pop;
  logic       we;
  logic [3:0] write_addr;
  logic       re;
  logic [3:0] read_addr;
  logic       push_ack;
  logic       pop_ack;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
`ifdef FIFO_ERR_FLAGS_EN
  logic       err_clr;
  logic       overflow;
  logic       underflow;
  logic       movf;
  logic       mudf;
`endif

  logic [8:0] mem [16];
  logic [8:0] data_in;
  logic [8:0] data_out;

  int         errors = 0;
  int         checks = 0;
  int         mcount;
  fifo_ptr_t  mwp;
  fifo_ptr_t  mrp;
  int         sb [$];
  logic       last_pa;
  logic       last_qa;

  typedef struct {
    logic p;
    logic q;
    logic pa;
    logic qa;
    int   cnt;
  } vec_t;

  vec_t tbl [10];

  fifo_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .pop          (pop),
`ifdef FIFO_ERR_FLAGS_EN
    .err_clr      (err_clr),
    .overflow     (overflow),
    .underflow    (underflow),
`endif
    .we           (we),
    .write_addr   (write_addr),
    .re           (re),
    .read_addr    (read_addr),
    .push_ack     (push_ack),
    .pop_ack      (pop_ack),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (we) mem[write_addr] <= data_in;
  end

  assign data_out = mem[read_addr];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // count must equal the pointer difference modulo 32
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (count !== 5'(dut.wr_ptr - dut.rd_ptr)) begin
        errors++;
        $display("FAIL count_vs_ptrs actual=%0d required=%0d",
                 count, 5'(dut.wr_ptr - dut.rd_ptr));
      end
    end
  end

  task automatic model_reset();
    mcount = 0;
    mwp = '0;
    mrp = '0;
    sb.delete();
`ifdef FIFO_ERR_FLAGS_EN
    movf = 1'b0;
    mudf = 1'b0;
`endif
  endtask

  task automatic chk_flags();
    chk("count", int'(count), mcount);
    chk("full", int'(full), int'(mcount == FIFO_DEPTH));
    chk("empty", int'(empty), int'(mcount == 0));
    chk("almost_full", int'(almost_full), int'(mcount >= 14));
    chk("almost_empty", int'(almost_empty), int'(mcount <= 2));
`ifdef FIFO_ERR_FLAGS_EN
    chk("overflow", int'(overflow), int'(movf));
    chk("underflow", int'(underflow), int'(mudf));
`endif
  endtask

  task automatic cyc(input logic p, input logic q, input logic [8:0] d);
    logic epa;
    logic eqa;
    @(negedge clk);
    push = p;
    pop = q;
    data_in = d;
    #1;
    eqa = q && (mcount > 0);
    epa = p && ((mcount < FIFO_DEPTH) || eqa);
    chk("pop_ack", int'(pop_ack), int'(eqa));
    chk("push_ack", int'(push_ack), int'(epa));
    chk("re", int'(re), int'(eqa));
    chk("we", int'(we), int'(epa));
    if (epa) chk("write_addr", int'(write_addr), int'(mwp[3:0]));
    if (eqa) begin
      chk("read_addr", int'(read_addr), int'(mrp[3:0]));
      if (sb.size() == 0) begin
        chk("sb_nonempty", 0, 1);
      end else begin
        chk("data_out", int'(data_out), sb.pop_front());
      end
    end
    if (epa) sb.push_back(int'(d));
`ifdef FIFO_ERR_FLAGS_EN
    if (p && !epa) movf = 1'b1;
    else if (err_clr) movf = 1'b0;
    if (q && !eqa) mudf = 1'b1;
    else if (err_clr) mudf = 1'b0;
`endif
    @(posedge clk);
    #1;
    if (epa) mwp = mwp + 1'b1;
    if (eqa) mrp = mrp + 1'b1;
    mcount = mcount + int'(epa) - int'(eqa);
    last_pa = epa;
    last_qa = eqa;
    chk_flags();
  endtask

  task automatic do_reset();
    @(negedge clk);
    push = 1'b0;
    pop = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 2};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 0};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1};
    tbl[9] = '{1'b0, 1'b1, 1'b0, 1'b1, 0};

    rst = 1'b1;
    push = 1'b1;
    pop = 1'b1;
    data_in = '0;
`ifdef FIFO_ERR_FLAGS_EN
    err_clr = 1'b0;
`endif
    model_reset();
    #3;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_almost_empty", int'(almost_empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_almost_full", int'(almost_full), 0);
    chk("rst_we", int'(we), 0);
    chk("rst_re", int'(re), 0);
    chk("rst_push_ack", int'(push_ack), 0);
    chk("rst_write_addr", int'(write_addr), 0);
    chk("rst_read_addr", int'(read_addr), 0);
`ifdef FIFO_ERR_FLAGS_EN
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_underflow", int'(underflow), 0);
`endif
    repeat (2) @(negedge clk);
    chk("rst_hold_count", int'(count), 0);
    rst = 1'b0;
    push = 1'b0;
    pop = 1'b0;
`ifdef FIFO_ERR_FLAGS_EN
    err_clr = 1'b1;
    repeat (3) cyc(1'b0, 1'b1, 9'h0);
    err_clr = 1'b0;
`else
    repeat (3) cyc(1'b0, 1'b1, 9'h0);
`endif

    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].p, tbl[i].q, 9'h40 + 9'(i));
      chk($sformatf("tbl%0d_push_ack", i), int'(last_pa), int'(tbl[i].pa));
      chk($sformatf("tbl%0d_pop_ack", i), int'(last_qa), int'(tbl[i].qa));
      chk($sformatf("tbl%0d_count", i), int'(count), tbl[i].cnt);
    end

    do_reset();
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b0, 9'h100 + 9'(i));
      chk($sformatf("fill%0d_addr", i), int'(dut.write_addr), (i + 1) % 16);
    end
    chk("fill_full", int'(full), 1);
    cyc(1'b1, 1'b0, 9'h1FF);
    chk("push17_ack", int'(last_pa), 0);
    chk("push17_count", int'(count), 16);

    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 9'h0);
    chk("drain_empty", int'(empty), 1);
    cyc(1'b0, 1'b1, 9'h0);

    cyc(1'b1, 1'b1, 9'h050);
    chk("pp_empty_push", int'(last_pa), 1);
    chk("pp_empty_pop", int'(last_qa), 0);
    chk("pp_empty_count", int'(count), 1);

    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 9'h058 + 9'(i));
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 9'h060 + 9'(i));
    chk("pp_mid_count", int'(count), 5);

    for (int i = 0; i < 11; i++) cyc(1'b1, 1'b0, 9'h080 + 9'(i));
    chk("refill_full", int'(full), 1);
    cyc(1'b1, 1'b1, 9'h1AA);
    chk("pp_full_push", int'(last_pa), 1);
    chk("pp_full_pop", int'(last_qa), 1);
    chk("pp_full_count", int'(count), 16);

    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 9'h0);
    chk("pre_rst_count", int'(count), 9);
    @(negedge clk);
    push = 1'b0;
    pop = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_count", int'(count), 0);
    chk("async_rst_empty", int'(empty), 1);
    chk("async_rst_read_addr", int'(read_addr), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b1, 1'b0, 9'h0AB);
    cyc(1'b0, 1'b1, 9'h0);

`ifdef FIFO_ERR_FLAGS_EN
    do_reset();
    cyc(1'b0, 1'b1, 9'h0);
    chk("underflow_set", int'(underflow), 1);
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 9'h0C0 + 9'(i));
    cyc(1'b1, 1'b0, 9'h1EE);
    chk("overflow_set", int'(overflow), 1);
    cyc(1'b0, 1'b0, 9'h0);
    chk("overflow_hold", int'(overflow), 1);
    err_clr = 1'b1;
    cyc(1'b0, 1'b0, 9'h0);
    err_clr = 1'b0;
    chk("clr_overflow", int'(overflow), 0);
    chk("clr_underflow", int'(underflow), 0);
    err_clr = 1'b1;
    cyc(1'b1, 1'b0, 9'h1EF);
    err_clr = 1'b0;
    chk("set_beats_clr", int'(overflow), 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
